// File: rtl/ffd_pipe_param.sv
// Purpose : parametrised registered delay line (WIDTH x DEPTH) with per-stage
//           valid tags, shared advance enable, synchronous flush and a
//           registered occupancy count.
// Latency : DEPTH enabled edges from capture to Q_out; stalls add latency 1:1.
// Backpressure: none; enable=0 freezes the whole line, flush empties it.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high clear of all state
//   datos      data presented to stage 0
//   valid_in   valid tag captured with datos
//   enable     advance strobe, shifts the whole line by one stage
//   flush      synchronous clear, wins over enable
//   Q_out      data of the last stage (registered)
//   valid_out  valid tag of the last stage (registered)
//   ocupacion  number of stages holding a valid word (registered)
module ffd_pipe_param #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] datos,
  input  logic             valid_in,
  input  logic             enable,
  input  logic             flush,
  output logic [WIDTH-1:0] Q_out,
  output logic             valid_out,
  output logic [CW-1:0]    ocupacion
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  // One word may enter and one may leave per advance, so the count moves by
  // at most one. It stays within 0..DEPTH because it tracks popcount(r_vld).
  assign w_cnt_nxt = r_cnt + CW'(valid_in) - CW'(r_vld[DEPTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_vld <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      // Flush discards whatever is being presented on this edge as well.
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_vld <= '0;
      r_cnt <= '0;
    end else if (enable) begin
      // Data shifts regardless of its tag; invalid words are just bubbles.
      r_data[0] <= datos;
      r_vld[0]  <= valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  assign Q_out     = r_data[DEPTH-1];
  assign valid_out = r_vld[DEPTH-1];
  assign ocupacion = r_cnt;

endmodule

// File: doc/ffd_pipe_param.md
# ffd_pipe_param

Parametrised registered delay line, WIDTH bits wide and DEPTH stages deep. Each stage carries a per-stage valid tag. The block adds a shared advance enable, a synchronous flush, and a registered occupancy count. It replaces hand-instanced chains of fixed-width enabled flip-flops wherever the design needs to delay or align data paths by a known number of enabled cycles.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset and on flush
- CW (localparam), $clog2(DEPTH+1), width of the occupancy count
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- datos  input  WIDTH  data presented to stage 0
- valid_in  input  1  tag for datos; captured into stage 0 together with datos
- enable  input  1  advance strobe; when 1 the whole line shifts by one stage
- flush  input  1  synchronous clear of all stages; takes priority over enable
- Q_out  output  WIDTH  data of stage DEPTH-1 (registered, no combinational path from inputs)
- valid_out  output  1  valid tag of stage DEPTH-1 (registered)
- ocupacion  output  CW  number of stages whose valid tag is 1 (registered)

## Operation
- State: data[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1], cnt (CW bits).
- Reset asserted, at any time including mid-operation, asynchronously forces:
  - all data stages to RESET_VAL;
  - all vld to 0;
  - cnt to 0.
  - As a result, Q_out=RESET_VAL, valid_out=0 and ocupacion=0 while reset is high.
- Priority at each rising edge, with reset low: flush > enable > hold.
- flush=1:
  - all data stages load RESET_VAL, all vld load 0, cnt loads 0;
  - datos/valid_in on that edge are discarded, even if enable=1.
- enable=1, flush=0:
  - data[0] <= datos and vld[0] <= valid_in;
  - for i >= 1: data[i] <= data[i-1] and vld[i] <= vld[i-1];
  - cnt <= cnt + valid_in - vld[DEPTH-1], which can never under- or overflow.
- enable=0, flush=0: all state holds. Inputs are ignored.
- Data moves regardless of its valid tag. Invalid words still shift and appear on Q_out with valid_out=0.
- DEPTH=1: a single stage. cnt is 0 or 1 and equals vld[0].
- Invariant: ocupacion always equals the popcount of vld[]. The bench checks this every cycle.

## Timing
- Latency: a word captured at enabled edge k appears on Q_out right after enabled edge k+DEPTH-1, i.e. after DEPTH enabled edges counting its capture edge.
- Disabled cycles add latency one-for-one. No data is lost or duplicated across stalls.
- Throughput: one word per enabled cycle.
- All outputs change only on a rising clk edge, or asynchronously on reset assertion.
- Reset release takes effect on the first rising edge after deassertion. No state change happens on the deassertion itself.
- enable and flush are level-sampled at each edge. There is no edge detection.

## Test plan
- Reset, WIDTH=3, DEPTH=3, RESET_VAL=0:
  - assert reset mid-cycle with the line full (ocupacion=3);
  - expect Q_out=0, valid_out=0 and ocupacion=0 immediately, before the next clk edge.
- Fill/drain with enable held at 1:
  - stimulus: datos 1,2,3,4 with valid_in=1;
  - expect Q_out=1 after the 3rd edge, then 2,3,4 on the following edges;
  - expect ocupacion to read 1,2,3,3;
  - then drive valid_in=0 and expect ocupacion to step 2,1,0 down to 0.
- Stall:
  - after capturing 5 and 6, drop enable for 4 cycles;
  - expect Q_out, valid_out and ocupacion frozen throughout;
  - restore enable and expect 5 then 6 to emerge with no gap or repeat.
- Bubbles:
  - stimulus: valid pattern 1,0,1 with datos 7,2,5;
  - expect valid_out pattern 1,0,1 with Q_out 7,2,5;
  - expect ocupacion to peak at 2.
- Flush priority:
  - line holds 3 valid words; assert flush=1 and enable=1 together with datos=6, valid_in=1;
  - after the edge, expect ocupacion=0, valid_out=0 and Q_out=0;
  - expect 6 never to appear on Q_out.
- Parametrisation:
  - rerun the fill/drain test with WIDTH=8, DEPTH=1, RESET_VAL=8'hA5;
  - expect Q_out=8'hA5 after reset, 1-edge latency, and ocupacion limited to the range 0..1.
